fifo_wr_arbiter: RTL

Round-robin write-port arbiter that shares the write side of `asynchronous_FIFO` (`w_en`, `wdata`, `full`) among `NREQ` producers in the write clock domain. Each producer offers bursts using valid/ready handshakes, with a last-beat marker. The arbiter grants one producer per burst and holds that grant until the last beat is accepted. It never writes while `full` is high, so the FIFO cannot overflow regardless of producer behaviour.

---
 rtl/fifo_arb_pkg.sv | 27 ++
 rtl/fifo_wr_arbiter_rr_pick.sv | 18 +
 rtl/fifo_wr_arbiter.sv | 101 ++++++++++
 3 files changed

// File: rtl/fifo_arb_pkg.sv
// Shared types and round-robin index math for the FIFO write-port arbiter.
// Used by the RTL and by the bench.
package fifo_arb_pkg;

  typedef enum logic {IDLE, BUSY} arb_state_t;

  localparam int STAT_W = 16;

  // First valid index scanning upward from last_ptr+1, modulo nreq (<= 8).
  function automatic logic [2:0] rr_next(
    input logic [7:0] valid,
    input logic [2:0] last_ptr,
    input int         nreq
  );
    logic [2:0] r;
    logic [2:0] idx;
    r = last_ptr;
    for (int k = 8; k >= 1; k--) begin
      if (k <= nreq) begin
        idx = 3'((int'(last_ptr) + k) % nreq);
        if (valid[idx]) r = idx;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: winner index and any-valid flag.
// Priority starts just above last_ptr and wraps.
module rr_pick
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ = 4,
  localparam int GW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid,
  input  logic [GW-1:0]   last_ptr,
  output logic [GW-1:0]   winner,
  output logic            any
);

  assign winner = GW'(rr_next(8'(valid), 3'(last_ptr), NREQ));
  assign any    = |valid;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter for the write side of an async FIFO.
// Optional per-requester beat counters: FIFO_WR_ARB_STATS_EN.
module fifo_wr_arbiter
  import fifo_arb_pkg::*;
#(
  parameter  int NREQ     = 4,
  parameter  int DATASIZE = 8,
  localparam int GW       = $clog2(NREQ)
) (
  input  logic                     clk1,
  input  logic                     rst1,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ-1:0]          req_last,
  input  logic [NREQ*DATASIZE-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  input  logic                     full,
`ifdef FIFO_WR_ARB_STATS_EN
  input  logic [GW-1:0]            stat_sel,
  output logic [STAT_W-1:0]        stat_cnt,
`endif
  output logic                     w_en,
  output logic [DATASIZE-1:0]      wdata,
  output logic [GW-1:0]            grant_id,
  output logic                     busy
);

  arb_state_t          state;
  logic                busy_q;
  logic [GW-1:0]       last_ptr;
  logic [GW-1:0]       pick;
  logic                any;
  logic                open;
  logic [DATASIZE-1:0] beats [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_beats
    assign beats[i] = req_data[i*DATASIZE +: DATASIZE];
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .valid    (req_valid),
    .last_ptr (last_ptr),
    .winner   (pick),
    .any      (any)
  );

  // full gates the write combinationally: no overflow window.
  assign open  = busy_q & ~full & ~rst1;
  assign w_en  = open & req_valid[grant_id];
  assign wdata = busy_q ? beats[grant_id] : '0;
  assign busy  = busy_q & ~rst1;

  always_comb begin
    req_ready = '0;
    if (open) req_ready[grant_id] = 1'b1;
  end

  always_ff @(posedge clk1) begin
    if (rst1) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      grant_id <= '0;
      last_ptr <= GW'(NREQ - 1);
    end else begin
      unique case (state)
        IDLE: begin
          if (any) begin
            grant_id <= pick;
            state    <= BUSY;
            busy_q   <= 1'b1;
          end
        end
        BUSY: begin
          if (w_en && req_last[grant_id]) begin
            last_ptr <= grant_id;
            state    <= IDLE;
            busy_q   <= 1'b0;
          end
        end
        default: begin
          state  <= IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [STAT_W-1:0] cnt [NREQ];

  always_ff @(posedge clk1) begin
    if (rst1) begin
      for (int i = 0; i < NREQ; i++) cnt[i] <= '0;
    end else if (w_en && cnt[grant_id] != '1) begin
      cnt[grant_id] <= cnt[grant_id] + 1'b1;
    end
  end

  assign stat_cnt = cnt[stat_sel];
`endif

endmodule
